// File: rtl/popcount_sampler_7seg.sv
// ---------------------------------------------------------------------------
// popcount_sampler_7seg
//
// Samples a bank of CHANNELS input bits, either on every clock (fast mode) or
// once per 2^PRESCALE_BITS clocks (slow mode). It counts how many channels
// were high and keeps the peak count seen since the last clear. One of the two
// is shown on an active-high seven-segment digit.
//
// Everything runs on clk. The slow rate is a clock enable produced by a free
// running prescaler. No clock is ever derived or muxed.
//
// Pipeline:
//   edge N   : samp <= din                   (only when en = 1)
//   edge N+1 : count/peak <= popcount(samp), sample_valid <= 1
// din therefore reaches count after two clocks.
//
// Parameters:
//   CHANNELS       number of input channels, 1..15
//   PRESCALE_BITS  prescaler width, 1..16 (slow period = 2^PRESCALE_BITS)
//   CNT_W          count width, derived from CHANNELS; leave at default
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset, clears all state
//   din           channel inputs, captured when en = 1
//   slow_mode     0: sample every clock, 1: sample once per prescaler period
//   hold_mode     0: display count, 1: display peak
//   clear         synchronous clear of the peak register
//   count         registered live popcount
//   peak          registered peak popcount since the last clear
//   sample_valid  one-cycle pulse when count/peak have just updated
//   seg           seven-segment drive, seg[0]=a .. seg[6]=g, active high
// ---------------------------------------------------------------------------
module popcount_sampler_7seg #(
    parameter int CHANNELS      = 6,
    parameter int PRESCALE_BITS = 12,
    parameter int CNT_W         = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    input  logic                slow_mode,
    input  logic                hold_mode,
    input  logic                clear,
    output logic [CNT_W-1:0]    count,
    output logic [CNT_W-1:0]    peak,
    output logic                sample_valid,
    output logic [6:0]          seg
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

    // Unsigned sum of the channel bits. CHANNELS always fits in CNT_W, so the
    // sum cannot wrap.
    function automatic logic [CNT_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + CNT_W'(v[i]);
        end
        return sum;
    endfunction

    // -----------------------------------------------------------------------
    // Prescaler and sample enable
    // -----------------------------------------------------------------------
    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     tick;
    logic                     en;

    // The counter is held at 0 whenever slow_mode is low. Re-entering slow
    // mode therefore always starts a full period, and the first slow sample
    // lands on the 2^PRESCALE_BITS-th clock after slow_mode rises.
    // NOTE: every clocked register in this file uses non-blocking (<=)
    // assignments. All registers then read pre-edge values, which keeps the
    // pipeline stages independent of the order of the always blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (slow_mode) begin
            prescaler <= prescaler + PRE_ONE;
        end else begin
            prescaler <= '0;
        end
    end

    assign tick = slow_mode && (prescaler == '1);
    assign en   = slow_mode ? tick : 1'b1;

    // -----------------------------------------------------------------------
    // Stage 1: capture the channels
    // -----------------------------------------------------------------------
    logic [CHANNELS-1:0] samp;
    logic                samp_fresh;

    // samp_fresh marks that samp was loaded on the previous edge, and that
    // stage 2 must consume it on this edge. It is cleared by reset, so an
    // in-flight sample is discarded and no sample_valid follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp       <= '0;
            samp_fresh <= 1'b0;
        end else begin
            samp_fresh <= en;
            if (en) begin
                samp <= din;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: popcount, peak tracking, valid pulse
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] samp_pop;

    assign samp_pop = popcount(samp);

    // clear is written last so that it wins over a simultaneous peak update.
    // The count update on the same edge still happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            peak         <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= samp_fresh;
            if (samp_fresh) begin
                count <= samp_pop;
                if (samp_pop > peak) begin
                    peak <= samp_pop;
                end
            end
            if (clear) begin
                peak <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Display: hex decode of the selected register, no added latency
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] disp;
    logic [3:0]       disp_nib;

    assign disp     = hold_mode ? peak : count;
    assign disp_nib = 4'(disp);

    // NOTE: seg gets a default before the case. Every path then assigns it,
    // so this always_comb cannot infer a latch.
    always_comb begin
        seg = 7'b0000000;
        unique case (disp_nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: tb/tb_popcount_sampler_7seg.sv
// ---------------------------------------------------------------------------
// Testbench for popcount_sampler_7seg.
//
// dut_a (6 channels, 4-bit prescaler) is compared on every clock against a
// behavioural model that follows the sampling rules directly:
//   - a sample is taken on every edge in fast mode, or on every 16th edge of
//     a continuous run of slow_mode;
//   - a taken sample appears one edge later as count/peak/sample_valid.
// dut_b (15 channels) covers the widest count and the digit F.
// ---------------------------------------------------------------------------
module tb_popcount_sampler_7seg;

    localparam int CH_A = 6;
    localparam int PB_A = 4;
    localparam int CW_A = 3;
    localparam int CH_B = 15;
    localparam int PB_B = 2;
    localparam int CW_B = 4;
    localparam int PERIOD_A = 1 << PB_A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [CH_A-1:0] din_a;
    logic            slow_a, hold_a, clear_a;
    logic [CW_A-1:0] count_a, peak_a;
    logic            valid_a;
    logic [6:0]      seg_a;

    logic [CH_B-1:0] din_b;
    logic            slow_b, hold_b, clear_b;
    logic [CW_B-1:0] count_b, peak_b;
    logic            valid_b;
    logic [6:0]      seg_b;

    popcount_sampler_7seg #(.CHANNELS(CH_A), .PRESCALE_BITS(PB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .slow_mode(slow_a),
        .hold_mode(hold_a), .clear(clear_a), .count(count_a), .peak(peak_a),
        .sample_valid(valid_a), .seg(seg_a)
    );

    popcount_sampler_7seg #(.CHANNELS(CH_B), .PRESCALE_BITS(PB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .slow_mode(slow_b),
        .hold_mode(hold_b), .clear(clear_b), .count(count_b), .peak(peak_b),
        .sample_valid(valid_b), .seg(seg_b)
    );

    // Segment patterns (g..a) for the hex digits 0..F.
    logic [6:0] seg_lut [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    int m_slow_run;   // consecutive edges seen with slow_mode high
    bit m_pending;    // a sample was taken on the previous edge
    int m_pend_val;   // popcount of that sample
    int m_count, m_peak;
    bit m_valid;

    task automatic model_reset();
        m_slow_run = 0;
        m_pending  = 0;
        m_pend_val = 0;
        m_count    = 0;
        m_peak     = 0;
        m_valid    = 0;
    endtask

    task automatic model_edge();
        bit take;
        if (!rst_n) begin
            model_reset();
            return;
        end
        take = !slow_a || ((m_slow_run % PERIOD_A) == PERIOD_A - 1);
        m_slow_run = slow_a ? m_slow_run + 1 : 0;
        m_valid = m_pending;
        if (m_pending) begin
            m_count = m_pend_val;
            if (m_pend_val > m_peak) m_peak = m_pend_val;
        end
        if (clear_a) m_peak = 0;
        m_pending = take;
        if (take) m_pend_val = $countones(din_a);
    endtask

    task automatic check_model();
        check("count_a", 32'(count_a), 32'(m_count));
        check("peak_a", 32'(peak_a), 32'(m_peak));
        check("valid_a", 32'(valid_a), 32'(m_valid));
        check("seg_a", 32'(seg_a), 32'(seg_lut[hold_a ? m_peak : m_count]));
    endtask

    // One clock: the model follows the rising edge, and the outputs are
    // compared on the falling edge. Callers drive inputs after step returns.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    int first_pulse, last_pulse, pulses, n;

    initial begin
        rst_n   = 1'b0;
        din_a   = 6'h3F;
        slow_a  = 1'b0;
        hold_a  = 1'b0;
        clear_a = 1'b0;
        din_b   = '0;
        slow_b  = 1'b0;
        hold_b  = 1'b0;
        clear_b = 1'b0;
        model_reset();

        // 1. Reset with all channels high, then release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_rst_count", 32'(count_a), 32'd0);
        check("t1_rst_peak", 32'(peak_a), 32'd0);
        check("t1_rst_valid", 32'(valid_a), 32'd0);
        check("t1_rst_seg", 32'(seg_a), 32'b0111111);
        check("t1_rst_seg_b", 32'(seg_b), 32'b0111111);
        rst_n = 1'b1;
        step();
        check("t1_valid_edge1", 32'(valid_a), 32'd0);
        step();
        check("t1_valid_edge2", 32'(valid_a), 32'd1);
        check("t1_count_edge2", 32'(count_a), 32'd6);

        // 2. Fast mode: 101101 -> 4, then 3F -> 6, with valid high throughout.
        din_a = 6'b101101;
        step();
        step();
        check("t2_count4", 32'(count_a), 32'd4);
        check("t2_seg4", 32'(seg_a), 32'b1100110);
        din_a = 6'h3F;
        step();
        step();
        check("t2_count6", 32'(count_a), 32'd6);
        check("t2_seg6", 32'(seg_a), 32'b1111101);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_valid_cont", 32'(valid_a), 32'd1);
        end

        // 5. 15 channels: all high gives F, then zero with the peak kept.
        din_b = 15'h7FFF;
        step();
        step();
        check("t5_count15", 32'(count_b), 32'd15);
        check("t5_seg15", 32'(seg_b), 32'b1110001);
        check("t5_valid_b", 32'(valid_b), 32'd1);
        din_b = '0;
        step();
        step();
        check("t5_count0", 32'(count_b), 32'd0);
        check("t5_peak15", 32'(peak_b), 32'd15);
        check("t5_seg0", 32'(seg_b), 32'b0111111);
        hold_b = 1'b1;
        #1;
        check("t5_seg_hold", 32'(seg_b), 32'b1110001);

        // 4. Peak and clear. The peak is cleared before the 5/2/3 sequence.
        din_a = 6'b000000;
        clear_a = 1'b1;
        step();
        din_a = 6'b011111;
        step();
        din_a = 6'b000011;
        clear_a = 1'b0;
        hold_a = 1'b1;
        step();
        check("t4_peak5", 32'(peak_a), 32'd5);
        check("t4_seg5a", 32'(seg_a), 32'b1101101);
        din_a = 6'b000111;
        step();
        check("t4_count2", 32'(count_a), 32'd2);
        check("t4_seg5b", 32'(seg_a), 32'b1101101);
        din_a = 6'b000001;
        clear_a = 1'b1;
        step();
        check("t4_clr_peak", 32'(peak_a), 32'd0);
        check("t4_clr_count", 32'(count_a), 32'd3);
        clear_a = 1'b0;
        step();
        check("t4_peak1", 32'(peak_a), 32'd1);
        hold_a = 1'b0;

        // 3. Slow mode with din toggling. The first slow step still shows the
        //    last fast-mode capture, so pulse timing is measured from step 2.
        slow_a = 1'b1;
        din_a = 6'b010101;
        first_pulse = 0;
        last_pulse = 0;
        pulses = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i >= 2 && valid_a) begin
                if (pulses == 0) first_pulse = i;
                else check("t3_interval", 32'(i - last_pulse), 32'(PERIOD_A));
                last_pulse = i;
                pulses++;
            end
            din_a = ~din_a;
        end
        check("t3_first_pulse", 32'(first_pulse), 32'(PERIOD_A + 1));
        check("t3_pulses", 32'(pulses), 32'd4);

        // 6. Asynchronous reset between edges during slow mode.
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_count", 32'(count_a), 32'd0);
        check("t6_peak", 32'(peak_a), 32'd0);
        check("t6_valid", 32'(valid_a), 32'd0);
        check("t6_seg", 32'(seg_a), 32'b0111111);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!valid_a && n < 100);
        check("t6_first_valid", 32'(n), 32'(PERIOD_A + 1));

        // Random phase: din, hold, clear and slow-mode toggles, all checked
        // against the model on every clock.
        for (int i = 0; i < 600; i++) begin
            din_a   = CH_A'($urandom);
            hold_a  = 1'($urandom);
            clear_a = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) slow_a = ~slow_a;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_sampler_7seg.md
Name: popcount_sampler_7seg

Overview:
- Samples a parametrised bank of input channels at a selectable rate and counts how many channels are high.
- Shows the count, or the peak count since the last clear, on an active-high seven-segment output.
- Sits behind the chip I/O mux as a user design.
- Everything runs in one clock domain. The slow sample rate comes from a clock-enable prescaler; no derived or muxed clocks are used.

Parameters:
- CHANNELS, 6: number of input channels; legal range 1..15.
- PRESCALE_BITS, 12: prescaler width; in slow mode one sample is taken every 2^PRESCALE_BITS clocks; legal range 1..16.
- CNT_W, $clog2(CHANNELS+1): count width; derived, must not be overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  CHANNELS  channel inputs, sampled on sample enable.
- slow_mode  in  1  0 = sample every clock; 1 = sample once per prescaler period.
- hold_mode  in  1  0 = display live count; 1 = display peak count since clear.
- clear  in  1  synchronous; resets the peak register.
- count  out  CNT_W  registered live popcount.
- peak  out  CNT_W  registered peak popcount.
- sample_valid  out  1  one-cycle pulse when count and peak have just updated.
- seg  out  7  segment drive, seg[0]=a .. seg[6]=g, active high.

Behaviour:
- Reset (rst_n low, asynchronous) clears all state to 0:
  - prescaler, sample register, count, peak and sample_valid are 0;
  - seg shows digit 0, 7'b0111111.
  - Reset taken mid-operation discards any in-flight sample; no sample_valid follows the release of reset.
- Prescaler:
  - An PRESCALE_BITS-wide up-counter, incrementing each clock while slow_mode=1 and wrapping from 2^PRESCALE_BITS-1 to 0.
  - While slow_mode=0 it is held at 0.
  - tick = slow_mode and (prescaler == all-ones).
  - en = slow_mode ? tick : 1.
  - The first slow sample occurs on the 2^PRESCALE_BITS-th clock after slow_mode rises.
- Stage 1: on an edge with en=1, samp <= din; otherwise samp holds.
- Stage 2: on the edge after a stage-1 capture:
  - count <= popcount(samp);
  - peak <= max(peak, popcount(samp));
  - sample_valid <= 1.
  - On every other edge sample_valid <= 0.
  - Latency from din to count is 2 clocks. In fast mode, count therefore follows din delayed by 2 and sample_valid stays high continuously.
- clear:
  - When asserted, peak <= 0 on that edge and has priority over a simultaneous stage-2 update. The stage-2 count update still occurs.
  - count is unaffected by clear.
- Display:
  - seg = hexdecode(hold_mode ? peak : count), combinational from registers with no latency beyond the selected register.
  - Encoding (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Mode changes:
  - Toggling slow_mode mid-period restarts the prescaler from 0.
  - Toggling hold_mode only changes seg, with no state change.
- Arithmetic:
  - The popcount is an unsigned sum of CHANNELS bits.
  - The maximum value CHANNELS always fits in CNT_W, so there is no overflow and no wrap.

Test Plan:
1. Reset with din=6'h3F, then release rst_n -> count=0, peak=0, sample_valid=0, seg=0111111. The first sample_valid occurs on the 2nd edge after release.
2. Fast mode with din=6'b101101 held -> count=4 after 2 clocks, seg=1100110. Then din=6'h3F -> count=6, seg=1111101, sample_valid high on every cycle.
3. Slow mode with PRESCALE_BITS=4 and din toggling each clock -> sample_valid pulses exactly every 16 clocks; count equals popcount(din) at the tick edge; count is stable between pulses.
4. Hold mode: drive samples of 5, then 2, then 3 -> peak=5 and seg=1101101 throughout. Assert clear on the edge where the stage-2 update of 3 occurs -> peak=0 and count=3. The next sample of 1 gives peak=1.
5. CHANNELS=15: din=15'h7FFF -> count=15, seg=1110001. Then din=0 -> count=0 while peak stays 15.
6. Assert rst_n low asynchronously between clock edges during slow mode -> all outputs 0 immediately. After release the prescaler restarts, and the first sample_valid comes 2^PRESCALE_BITS+1 clocks later.
